neighbor_output_sender: RTL and testbench

//  Transmit side of the neighbor link. Takes halo partial sums from the multiplier/crossbar stage (products

---
 rtl/neighbor_output_sender_if.sv | 46 ++++
 rtl/neighbor_output_sender.sv | 243 ++++++++++++++++++++++++
 tb/tb_neighbor_output_sender.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/neighbor_output_sender_if.sv
// ---------------------------------------------------------------------------
// neighbor_output_sender_if
// Bundles the product-side input lanes, the neighbor-link output lanes and
// the flush handshake of neighbor_output_sender.
//   master : used by the sender itself (accepts products, drives the link)
//   slave  : used by the surrounding logic (offers products, observes link)
// Signals
//   in_value/in_row/in_column/in_valid [IN_LANES] : halo candidates
//   in_ready                                      : lanes accepted this cycle
//   neighbor_busy                                 : receiver holding leftovers
//   neighbor_output_* [8]                         : registered link lanes
//   flush_req / flush_done                        : drain request / completion
// ---------------------------------------------------------------------------
interface neighbor_output_sender_if #(
  parameter int TILE_SIZE = 256,
  parameter int IN_LANES  = 4
);
  localparam int C = $clog2(TILE_SIZE);

  logic [7:0]   in_value  [IN_LANES];
  logic [C+1:0] in_row    [IN_LANES];
  logic [C+1:0] in_column [IN_LANES];
  logic         in_valid  [IN_LANES];
  logic         in_ready;

  logic         neighbor_busy;
  logic [7:0]   neighbor_output_value        [8];
  logic [C-1:0] neighbor_output_row          [8];
  logic [C-1:0] neighbor_output_column       [8];
  logic         neighbor_output_write_enable [8];

  logic         flush_req;
  logic         flush_done;

  modport master (
    input  in_value, in_row, in_column, in_valid, neighbor_busy, flush_req,
    output in_ready, neighbor_output_value, neighbor_output_row,
           neighbor_output_column, neighbor_output_write_enable, flush_done
  );

  modport slave (
    output in_value, in_row, in_column, in_valid, neighbor_busy, flush_req,
    input  in_ready, neighbor_output_value, neighbor_output_row,
           neighbor_output_column, neighbor_output_write_enable, flush_done
  );
endinterface

// File: rtl/neighbor_output_sender.sv
// ---------------------------------------------------------------------------
// neighbor_output_sender
// Transmit side of the neighbor link. Products whose tile-relative row or
// column falls outside [0, TILE_SIZE) are translated into the neighbor's
// frame (low C bits, i.e. modulo TILE_SIZE), queued in order, and sent up to
// 8 per cycle on registered output lanes. A presented batch is held while
// the receiver reports neighbor_busy.
// Ports
//   clk               clock
//   reset_n           asynchronous active-low reset
//   bus (master)      product lanes, neighbor link lanes, flush handshake
//   stat_sent_count   entries consumed by the neighbor (saturating)
//   stat_stall_cycles cycles with a batch presented while busy (saturating)
// Configuration
//   NEIGHBOR_OUT_STATS_EN : when defined, adds the two stat_* outputs.
// Notes
//   TILE_SIZE and FIFO_DEPTH must be powers of two; FIFO_DEPTH >= IN_LANES+8.
// ---------------------------------------------------------------------------
module neighbor_output_sender #(
  parameter int TILE_SIZE  = 256,
  parameter int IN_LANES   = 4,
  parameter int FIFO_DEPTH = 32
) (
  input  logic clk,
  input  logic reset_n,
`ifdef NEIGHBOR_OUT_STATS_EN
  output logic [31:0] stat_sent_count,
  output logic [31:0] stat_stall_cycles,
`endif
  neighbor_output_sender_if.master bus
);

  localparam int C         = $clog2(TILE_SIZE);
  localparam int CW        = C + 2;
  localparam int OUT_LANES = 8;
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int CNTW      = AW + 1;
  localparam int PW        = $clog2(IN_LANES + 1);
  localparam int KW        = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SEND  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Halo queue storage (data only; occupancy lives in count_reg)
  logic [7:0]   mem_value  [FIFO_DEPTH];
  logic [C-1:0] mem_row    [FIFO_DEPTH];
  logic [C-1:0] mem_column [FIFO_DEPTH];

  logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [CNTW-1:0] count_reg, count_next;
  logic [1:0]      state_reg, state_next;
  logic            flush_done_reg;
  logic            drain_done;

  logic [7:0]           value_reg  [OUT_LANES];
  logic [C-1:0]         row_reg    [OUT_LANES];
  logic [C-1:0]         column_reg [OUT_LANES];
  logic [OUT_LANES-1:0] we_reg;

  // ---------------- input side ----------------
  logic [IN_LANES-1:0] valid;
  logic [IN_LANES-1:0] halo;
  logic [PW-1:0]       slot [IN_LANES];
  logic [PW-1:0]       push_n;
  logic [PW-1:0]       pushed;
  logic                in_ready;
  logic                accept;

  for (genvar gi = 0; gi < IN_LANES; gi++) begin : g_in_lane
    assign valid[gi] = bus.in_valid[gi];
    // Coordinates are C+2-bit signed: any set bit above the low C bits means
    // either negative (sign bit) or >= TILE_SIZE, i.e. outside the tile.
    assign halo[gi]  = bus.in_valid[gi] &
                       ((|bus.in_row[gi][CW-1:C]) | (|bus.in_column[gi][CW-1:C]));
  end

  // Compaction: each halo lane lands at the number of halo lanes below it.
  always_comb begin
    push_n = '0;
    for (int i = 0; i < IN_LANES; i++) begin
      slot[i] = push_n;
      push_n  = push_n + PW'(halo[i]);
    end
  end

  assign in_ready = (state_reg != ST_DRAIN) &&
                    ((CNTW'(FIFO_DEPTH) - count_reg) >= CNTW'(IN_LANES));
  assign accept   = in_ready & (|valid);
  assign pushed   = accept ? push_n : '0;

  // ---------------- output side ----------------
  logic            presented;
  logic            consume;
  logic            load;
  logic [KW-1:0]   pop_k;
  logic [KW-1:0]   popped;
  logic [AW-1:0]   rd_idx   [OUT_LANES];
  logic [OUT_LANES-1:0] lane_hit;

  assign presented = |we_reg;
  assign consume   = presented & ~bus.neighbor_busy;
  // A new batch is loaded whenever the current one is taken or nothing is
  // on the link; a busy receiver freezes the lanes untouched.
  assign load      = consume | ~presented;
  assign pop_k     = (count_reg >= CNTW'(OUT_LANES)) ? KW'(OUT_LANES) : count_reg[KW-1:0];
  assign popped    = load ? pop_k : '0;

  for (genvar gi = 0; gi < OUT_LANES; gi++) begin : g_out_lane
    assign rd_idx[gi]   = rd_ptr_reg + AW'(gi);
    assign lane_hit[gi] = (KW'(gi) < pop_k);

    assign bus.neighbor_output_value[gi]        = value_reg[gi];
    assign bus.neighbor_output_row[gi]          = row_reg[gi];
    assign bus.neighbor_output_column[gi]       = column_reg[gi];
    assign bus.neighbor_output_write_enable[gi] = we_reg[gi];
  end

  assign bus.in_ready   = in_ready;
  assign bus.flush_done = flush_done_reg;

  // Pop uses the occupancy before this cycle's push, so a product accepted
  // now is first eligible for the link on the following load.
  assign count_next  = count_reg + CNTW'(pushed) - CNTW'(popped);
  assign wr_ptr_next = wr_ptr_reg + AW'(pushed);
  assign rd_ptr_next = rd_ptr_reg + AW'(popped);

  // ---------------- control FSM ----------------
  always_comb begin
    state_next = state_reg;
    drain_done = 1'b0;
    case (state_reg)
      ST_DRAIN: begin
        // Inputs are blocked here, so a load with an empty queue means the
        // last batch has just been taken (or nothing was presented).
        if (load && (count_reg == '0)) begin
          state_next = ST_IDLE;
          drain_done = 1'b1;
        end
      end
      default: begin
        if (bus.flush_req) begin
          if (load && (count_reg == '0) && !accept) begin
            // Nothing queued, nothing left on the link: complete at once.
            state_next = ST_IDLE;
            drain_done = 1'b1;
          end else begin
            state_next = ST_DRAIN;
          end
        end else if (load) begin
          state_next = (pop_k != '0) ? ST_SEND : ST_IDLE;
        end
      end
    endcase
  end

  // ---------------- queue data write ----------------
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < IN_LANES; i++) begin
        if (halo[i]) begin
          mem_value [wr_ptr_reg + AW'(slot[i])] <= bus.in_value[i];
          mem_row   [wr_ptr_reg + AW'(slot[i])] <= bus.in_row[i][C-1:0];
          mem_column[wr_ptr_reg + AW'(slot[i])] <= bus.in_column[i][C-1:0];
        end
      end
    end
  end

  // ---------------- state and output registers ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      state_reg      <= ST_IDLE;
      flush_done_reg <= 1'b0;
      we_reg         <= '0;
      for (int j = 0; j < OUT_LANES; j++) begin
        value_reg[j]  <= '0;
        row_reg[j]    <= '0;
        column_reg[j] <= '0;
      end
    end else begin
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      count_reg      <= count_next;
      state_reg      <= state_next;
      flush_done_reg <= drain_done;
      if (load) begin
        for (int j = 0; j < OUT_LANES; j++) begin
          if (lane_hit[j]) begin
            value_reg[j]  <= mem_value[rd_idx[j]];
            row_reg[j]    <= mem_row[rd_idx[j]];
            column_reg[j] <= mem_column[rd_idx[j]];
            we_reg[j]     <= 1'b1;
          end else begin
            value_reg[j]  <= '0;
            row_reg[j]    <= '0;
            column_reg[j] <= '0;
            we_reg[j]     <= 1'b0;
          end
        end
      end
    end
  end

`ifdef NEIGHBOR_OUT_STATS_EN
  // ---------------- saturating link statistics ----------------
  logic [31:0] sent_reg;
  logic [31:0] stall_reg;
  logic [KW-1:0] we_pop;
  logic [32:0] sent_sum;

  always_comb begin
    we_pop = '0;
    for (int j = 0; j < OUT_LANES; j++) begin
      we_pop = we_pop + KW'(we_reg[j]);
    end
  end

  assign sent_sum = {1'b0, sent_reg} + 33'(we_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sent_reg  <= '0;
      stall_reg <= '0;
    end else begin
      if (consume) begin
        sent_reg <= sent_sum[32] ? '1 : sent_sum[31:0];
      end
      if (presented && bus.neighbor_busy && (stall_reg != '1)) begin
        stall_reg <= stall_reg + 32'd1;
      end
    end
  end

  assign stat_sent_count   = sent_reg;
  assign stat_stall_cycles = stall_reg;
`endif

endmodule

// File: tb/tb_neighbor_output_sender.sv
module tb_neighbor_output_sender;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_err;
  int   exp_next;
  int   n_got;

`ifdef NEIGHBOR_OUT_STATS_EN
  logic [31:0] stat_sent_count;
  logic [31:0] stat_stall_cycles;
`endif

  neighbor_output_sender_if #(.TILE_SIZE(256), .IN_LANES(4)) bus_if ();

  neighbor_output_sender #(
    .TILE_SIZE (256),
    .IN_LANES  (4),
    .FIFO_DEPTH(32)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
`ifdef NEIGHBOR_OUT_STATS_EN
    .stat_sent_count  (stat_sent_count),
    .stat_stall_cycles(stat_stall_cycles),
`endif
    .bus              (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_lanes();
    for (int i = 0; i < 4; i++) begin
      bus_if.in_valid[i]  = 1'b0;
      bus_if.in_value[i]  = 8'h00;
      bus_if.in_row[i]    = 10'h000;
      bus_if.in_column[i] = 10'h000;
    end
  endtask

  task automatic set_lane(input int lane, input int row, input int col, input int val);
    bus_if.in_valid[lane]  = 1'b1;
    bus_if.in_row[lane]    = 10'(row);
    bus_if.in_column[lane] = 10'(col);
    bus_if.in_value[lane]  = 8'(val);
  endtask

  function automatic logic [7:0] we_mask();
    logic [7:0] m;
    for (int j = 0; j < 8; j++) m[j] = bus_if.neighbor_output_write_enable[j];
    return m;
  endfunction

  // Consume-side scoreboard: values must appear as a contiguous ascending run.
  task automatic take_batch(input string tag);
    for (int j = 0; j < 8; j++) begin
      if (bus_if.neighbor_output_write_enable[j]) begin
        chk(tag, 32'(bus_if.neighbor_output_value[j]), 32'(exp_next & 8'hFF));
        exp_next++;
        n_got++;
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_n = 1'b0;
    bus_if.neighbor_busy = 1'b0;
    bus_if.flush_req = 1'b0;
    clear_lanes();
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    chk("rst_we", 32'(we_mask()), 32'h00);
    chk("rst_val0", 32'(bus_if.neighbor_output_value[0]), 32'h00);
    chk("rst_flush_done", 32'(bus_if.flush_done), 32'h0);
    chk("rst_in_ready", 32'(bus_if.in_ready), 32'h1);
    reset_n = 1'b1;
    step();
    $display("reset: checked idle outputs");

    // 1: single halo entry, row -1 wraps to 255
    set_lane(0, -1, 5, 8'h3C);
    step();
    clear_lanes();
    chk("t1_not_before_load", 32'(we_mask()), 32'h00);
    step();
    chk("t1_we", 32'(we_mask()), 32'h01);
    chk("t1_val", 32'(bus_if.neighbor_output_value[0]), 32'h3C);
    chk("t1_row", 32'(bus_if.neighbor_output_row[0]), 32'd255);
    chk("t1_col", 32'(bus_if.neighbor_output_column[0]), 32'd5);
    chk("t1_lane1_data", 32'(bus_if.neighbor_output_value[1]), 32'h00);
    step();
    chk("t1_done", 32'(we_mask()), 32'h00);
    $display("txn1: single halo entry row -1 -> 255");

    // 2: in-tile lane dropped, remaining lanes compacted in order
    set_lane(0, 10, 0, 8'h11);
    set_lane(1, 256, 0, 8'h12);
    set_lane(2, -2, 0, 8'h13);
    set_lane(3, 300, 0, 8'h14);
    step();
    clear_lanes();
    step();
    chk("t2_we", 32'(we_mask()), 32'h07);
    chk("t2_row0", 32'(bus_if.neighbor_output_row[0]), 32'd0);
    chk("t2_row1", 32'(bus_if.neighbor_output_row[1]), 32'd254);
    chk("t2_row2", 32'(bus_if.neighbor_output_row[2]), 32'd44);
    chk("t2_val0", 32'(bus_if.neighbor_output_value[0]), 32'h12);
    chk("t2_val2", 32'(bus_if.neighbor_output_value[2]), 32'h14);
    step();
    chk("t2_done", 32'(we_mask()), 32'h00);
    $display("txn2: compaction rows 0,254,44");

    // 3: busy hold with 12 entries; first batch frozen, then 8 delivered
    bus_if.neighbor_busy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      for (int l = 0; l < 4; l++) set_lane(l, -1, c * 4 + l, c * 4 + l);
      step();
    end
    clear_lanes();
    for (int h = 0; h < 3; h++) begin
      chk("t3_hold_we", 32'(we_mask()), 32'h0F);
      chk("t3_hold_val0", 32'(bus_if.neighbor_output_value[0]), 32'd0);
      chk("t3_hold_val3", 32'(bus_if.neighbor_output_value[3]), 32'd3);
      step();
    end
    bus_if.neighbor_busy = 1'b0;
    step();
    chk("t3_batch_we", 32'(we_mask()), 32'hFF);
    for (int j = 0; j < 8; j++) begin
      chk("t3_batch_val", 32'(bus_if.neighbor_output_value[j]), 32'(4 + j));
      chk("t3_batch_col", 32'(bus_if.neighbor_output_column[j]), 32'(4 + j));
    end
    step();
    chk("t3_done", 32'(we_mask()), 32'h00);
    $display("txn3: busy hold then 8-entry batch in order");

    // 4: fill to 29 queued -> in_ready low; a rejected offer must not enter
    bus_if.neighbor_busy = 1'b1;
    for (int c = 0; c < 8; c++) begin
      for (int l = 0; l < 4; l++) set_lane(l, -1, 0, 8'h40 + c * 4 + l);
      step();
    end
    clear_lanes();
    set_lane(0, -1, 0, 8'h60);
    step();
    clear_lanes();
    chk("t4_full_ready", 32'(bus_if.in_ready), 32'h0);
    set_lane(0, -1, 0, 8'hEE);
    step();
    clear_lanes();
    chk("t4_still_full", 32'(bus_if.in_ready), 32'h0);
    exp_next = 8'h40;
    n_got = 0;
    take_batch("t4_order");
    bus_if.neighbor_busy = 1'b0;
    step();
    chk("t4_ready_after_pop", 32'(bus_if.in_ready), 32'h1);
    take_batch("t4_order");
    for (int i = 0; i < 8; i++) begin
      step();
      if (we_mask() == 8'h00) break;
      take_batch("t4_order");
    end
    chk("t4_total", 32'(n_got), 32'd33);
    chk("t4_last", 32'(exp_next), 32'h61);
    $display("txn4: fill to 29, backpressure, 33 entries in order");

    // 5: flush with 4 presented + 10 queued -> batches 8 then 2, then done
    bus_if.neighbor_busy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      for (int l = 0; l < 4; l++) set_lane(l, -1, 0, 8'h80 + c * 4 + l);
      step();
    end
    clear_lanes();
    set_lane(0, -1, 0, 8'h8C);
    set_lane(1, -1, 0, 8'h8D);
    step();
    clear_lanes();
    bus_if.flush_req = 1'b1;
    step();
    bus_if.flush_req = 1'b0;
    chk("t5_drain_ready", 32'(bus_if.in_ready), 32'h0);
    chk("t5_no_early_done", 32'(bus_if.flush_done), 32'h0);
    bus_if.neighbor_busy = 1'b0;
    step();
    chk("t5_batch8_we", 32'(we_mask()), 32'hFF);
    chk("t5_batch8_val0", 32'(bus_if.neighbor_output_value[0]), 32'h84);
    chk("t5_batch8_val7", 32'(bus_if.neighbor_output_value[7]), 32'h8B);
    chk("t5_done_low1", 32'(bus_if.flush_done), 32'h0);
    step();
    chk("t5_batch2_we", 32'(we_mask()), 32'h03);
    chk("t5_batch2_val1", 32'(bus_if.neighbor_output_value[1]), 32'h8D);
    chk("t5_done_low2", 32'(bus_if.flush_done), 32'h0);
    step();
    chk("t5_empty_we", 32'(we_mask()), 32'h00);
    chk("t5_flush_done", 32'(bus_if.flush_done), 32'h1);
    step();
    chk("t5_done_pulse", 32'(bus_if.flush_done), 32'h0);
    chk("t5_ready_back", 32'(bus_if.in_ready), 32'h1);
    bus_if.flush_req = 1'b1;
    step();
    bus_if.flush_req = 1'b0;
    chk("t5_idle_flush_done", 32'(bus_if.flush_done), 32'h1);
    step();
    chk("t5_idle_flush_pulse", 32'(bus_if.flush_done), 32'h0);
    $display("txn5: flush drain 8+2 and idle flush");

    // 6: async reset with 20 queued discards everything
    bus_if.neighbor_busy = 1'b1;
    for (int c = 0; c < 6; c++) begin
      for (int l = 0; l < 4; l++) set_lane(l, -1, 0, 8'hA0 + c * 4 + l);
      step();
    end
    clear_lanes();
    chk("t6_presented", 32'(we_mask()), 32'h0F);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async_we", 32'(we_mask()), 32'h00);
    chk("t6_async_val", 32'(bus_if.neighbor_output_value[0]), 32'h00);
    step();
    reset_n = 1'b1;
    bus_if.neighbor_busy = 1'b0;
    step();
    chk("t6_no_stale1", 32'(we_mask()), 32'h00);
    step();
    chk("t6_no_stale2", 32'(we_mask()), 32'h00);
`ifdef NEIGHBOR_OUT_STATS_EN
    chk("t6_stat_sent_rst", stat_sent_count, 32'd0);
    chk("t6_stat_stall_rst", stat_stall_cycles, 32'd0);
`endif
    set_lane(0, 3, 256, 8'h5A);
    step();
    clear_lanes();
    step();
    chk("t6_fresh_we", 32'(we_mask()), 32'h01);
    chk("t6_fresh_val", 32'(bus_if.neighbor_output_value[0]), 32'h5A);
    chk("t6_fresh_col", 32'(bus_if.neighbor_output_column[0]), 32'd0);
    step();
    chk("t6_fresh_done", 32'(we_mask()), 32'h00);
    $display("txn6: async reset discards queue");

`ifdef NEIGHBOR_OUT_STATS_EN
    bus_if.neighbor_busy = 1'b1;
    set_lane(0, -1, 1, 8'h5B);
    step();
    clear_lanes();
    step();
    step();
    step();
    bus_if.neighbor_busy = 1'b0;
    step();
    chk("stat_sent", stat_sent_count, 32'd2);
    chk("stat_stall", stat_stall_cycles, 32'd2);
    $display("stats: sent and stall counters");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
